// File: rtl/camif_reg_arbiter_if.sv
// AXI4-Lite register bus between the arbiter and the camif S00_AXI slave.
interface camif_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/camif_reg_arbiter.sv
// Round-robin sharing of the camif AXI4-Lite register slave
// between the ISP control FSM (req0) and the PS config bridge (req1).
module camif_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rsp0_valid,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  output logic [1:0]            rsp0_resp,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [1:0]            rsp1_resp,
  camif_reg_arbiter_if.master   m_axi
);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  state_t                state;
  logic                  last_grant;
  logic                  owner;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  awvalid_q;
  logic                  wvalid_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic                  rready_q;

  logic                  any_req;
  logic                  sel;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  aw_done;
  logic                  w_done;
  logic                  fin;
  logic [DATA_WIDTH-1:0] fin_rdata;
  logic [1:0]            fin_resp;

  always_comb begin
    any_req   = req0_valid | req1_valid;
    sel       = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    sel_we    = sel ? req1_we : req0_we;
    sel_addr  = (sel ? req1_addr : req0_addr) & WORD_MASK;
    sel_wdata = sel ? req1_wdata : req0_wdata;
    aw_done   = ~awvalid_q | m_axi.awready;
    w_done    = ~wvalid_q | m_axi.wready;
    fin       = ((state == WR_RESP) & m_axi.bvalid)
              | ((state == RD_DATA) & m_axi.rvalid);
    fin_rdata = (state == RD_DATA) ? m_axi.rdata : '0;
    fin_resp  = (state == RD_DATA) ? m_axi.rresp : m_axi.bresp;
  end

  // Grants only leave IDLE, so a withdrawn request never commits.
  assign req0_ready = (state == IDLE) & any_req & ~sel;
  assign req1_ready = (state == IDLE) & any_req & sel;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp0_resp  <= '0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= '0;
      rsp1_resp  <= '0;
    end else begin
      rsp0_valid <= fin & ~owner;
      rsp1_valid <= fin & owner;
      if (fin & ~owner) begin
        rsp0_rdata <= fin_rdata;
        rsp0_resp  <= fin_resp;
      end
      if (fin & owner) begin
        rsp1_rdata <= fin_rdata;
        rsp1_resp  <= fin_resp;
      end
      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= sel;
            last_grant <= sel;
            if (sel_we) begin
              awaddr_q  <= sel_addr;
              wdata_q   <= sel_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= WR;
            end else begin
              araddr_q  <= sel_addr;
              arvalid_q <= 1'b1;
              state     <= RD_ADDR;
            end
          end
        end
        WR: begin
          // AW and W retire independently, in either order.
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready) wvalid_q <= 1'b0;
          if (aw_done & w_done) begin
            bready_q <= 1'b1;
            state    <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            state    <= RESP;
          end
        end
        RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (m_axi.rvalid) begin
            rready_q <= 1'b0;
            state    <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

endmodule

// File: doc/camif_reg_arbiter.md
Name: camif_reg_arbiter

Overview:
- Two-requester round-robin arbiter and AXI4-Lite master that shares the single xil_camif S00_AXI register slave.
- Requester 0 is the ISP control FSM and requester 1 is the PS-side config bridge; both use a simple valid/ready word-access port.
- Serializes one access at a time, drives AW/W/B or AR/R, and returns read data and response to the owning requester.

Parameters:
- ADDR_WIDTH, 4, AXI4-Lite byte address width (camif has 4 x 32-bit registers).
- DATA_WIDTH, 32, register data width; must be 32.

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- reqN_valid  in  1  access request, N=0,1
- reqN_we  in  1  1=write, 0=read
- reqN_addr  in  ADDR_WIDTH  byte address, [1:0] ignored
- reqN_wdata  in  32  write data
- reqN_ready  out  1  request accepted this cycle
- rspN_valid  out  1  one-cycle completion pulse
- rspN_rdata  out  32  read data (0 for writes)
- rspN_resp  out  2  AXI response code
- m_axi_awaddr  out  ADDR_WIDTH
- m_axi_awprot  out  3  tied 3'b000
- m_axi_awvalid / m_axi_awready  out/in  1
- m_axi_wdata  out  32
- m_axi_wstrb  out  4  tied 4'hF
- m_axi_wvalid / m_axi_wready  out/in  1
- m_axi_bresp  in  2
- m_axi_bvalid / m_axi_bready  in/out  1
- m_axi_araddr  out  ADDR_WIDTH
- m_axi_arprot  out  3  tied 3'b000
- m_axi_arvalid / m_axi_arready  out/in  1
- m_axi_rdata  in  32
- m_axi_rresp  in  2
- m_axi_rvalid / m_axi_rready  in/out  1

Behaviour:
- One clock aclk; reset is synchronous, active-high on areset.
- Reset values:
  - all valid/ready outputs 0, all data/address outputs 0.
  - last_grant = 1, so requester 0 wins first.
  - FSM in IDLE.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE arbitration:
  - If only one reqN_valid is high, grant it.
  - If both are high, grant the one not equal to last_grant.
  - On grant: pulse reqN_ready for 1 cycle, latch we/addr (with [1:0] forced 0)/wdata, update last_grant, then go to WR (we=1) or RD_ADDR (we=0).
  - No ready is issued outside IDLE.
- WR:
  - awvalid and wvalid both assert in the first WR cycle.
  - Each deasserts independently on its own handshake, so AW and W may complete in either order or the same cycle.
  - When both are done, go to WR_RESP.
- WR_RESP: bready=1; on bvalid capture bresp, set rdata=0, go to RESP.
- RD_ADDR: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1; on rvalid capture rdata/rresp, go to RESP.
- RESP:
  - rspN_valid=1 for exactly 1 cycle on the granted requester only, with rdata/resp valid that cycle.
  - Next state IDLE; a new grant is possible the following cycle.
- rspN_rdata/resp hold their value until the next response to the same requester.
- Valid stability: awvalid/wvalid/arvalid never drop before their handshake; address/data are stable while valid.
- Requester rules: a requester must hold valid and fields stable until ready. Deasserting before ready withdraws the request with no effect.
- Minimum latency with a zero-wait slave (aclk cycles):
  - write: grant -> rsp = 4 (IDLE, WR, WR_RESP, RESP).
  - read: grant -> rsp = 4 (IDLE, RD_ADDR, RD_DATA, RESP).
- SLVERR/DECERR are passed through unchanged; the arbiter does not retry.
- areset mid-transaction: FSM returns to IDLE at once, all AXI valids and readies drop, and no rsp pulse is issued. The integrator resets the slave together with the arbiter.

Test Plan:
- Write then read, single requester: req0 writes 0x0000_0001 to 0x0 and 0x0000_0004 to 0xC, then reads 0x0 and 0xC -> rsp0_rdata = 0x1 then 0x4, resp=0, each grant->rsp = 4 cycles with zero-wait slave.
- Simultaneous requests after reset: req0 reads 0x4 and req1 writes 0x8=0xA5A5_0000, both valid same cycle -> req0 granted first, req1 granted the cycle after rsp0, rsp1_resp=0.
- Round-robin fairness: both requesters hold valid continuously for 8 accesses -> grants alternate 0,1,0,1…, neither starved.
- AW/W skew: slave asserts wready 3 cycles before awready, then the reverse, then both in the same cycle -> exactly one AW and one W handshake each, single rsp pulse.
- Backpressure and error: arready delayed 5 cycles and rvalid delayed 7 cycles with rresp=2'b10 -> arvalid held and araddr stable throughout, rsp0_resp=2'b10.
- Reset mid-write: areset asserted in WR after the AW handshake but before W -> all m_axi valids 0 next cycle, no rspN_valid, new request accepted after reset release.
